fetch_decode: RTL and testbench
===============================

// Module: fetch_decode
// PURPOSE
//  Front-end stage of the 8-bit core, directly upstream of the execute stage.
//  Fetches 16-bit instruction words from the 32-entry instruction memory and splits them into
//  opcode/am/rd/rs1/rs2/mem_addr fields. Presents one decoded instruction at a time with a valid/stall handshake.
//  Resolves JMP and HALT locally; neither is issued to execute.
// PARAMETERS
//  PC_W       5       instruction address width (32 words)
//  INSTR_W    16      instruction word width
//  RESET_PC   5'd0    PC value loaded on reset and on start
//  OP_JMP     4'hE    opcode: unconditional jump, target = instr[4:0]
//  OP_HALT    4'hF    opcode: stop fetching
// PORTS
//  clk             in   1        clock, rising edge
//  reset           in   1        asynchronous, active-low reset
//  start           in   1        begin fetching at RESET_PC (honoured in IDLE/HALTED only)
//  stall           in   1        execute not ready; hold the current issued instruction
//  imem_rd_en      out  1        instruction memory read strobe
//  imem_addr       out  PC_W     instruction memory address
//  imem_data       in   INSTR_W  read data, valid exactly 1 cycle after imem_rd_en
//  issue_valid     out  1        decoded fields valid (drives execute enable)
//  opcode          out  4        instr[15:12]
//  am              out  1        instr[11]; 0 = rs2 operand, 1 = memory operand
//  rd              out  3        instr[10:8]
//  rs1             out  3        instr[7:5]
//  rs2             out  3        instr[4:2]
//  mem_addr        out  5        instr[4:0] (overlaps rs2; execute selects by am)
//  instr_mem_addr  out  PC_W     address the issued instruction was fetched from
//  halted          out  1        HALT decoded; fetch stopped
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, pc=RESET_PC, IR=0, every output 0; dominates all other inputs.
//  FSM states: IDLE, FETCH, WAIT, ISSUE, HALTED.
//   IDLE:   start=1 -> pc<=RESET_PC, FETCH.
//   FETCH:  imem_rd_en=1, imem_addr=pc for exactly this cycle -> WAIT.
//   WAIT:   IR<=imem_data, fetch_pc<=pc -> ISSUE.
//   ISSUE:  decode IR combinationally into registered outputs, latched on WAIT->ISSUE edge.
//    - opcode==OP_JMP: issue_valid stays 0; pc<=IR[4:0]; -> FETCH next cycle.
//    - opcode==OP_HALT: issue_valid 0; halted<=1; -> HALTED.
//    - else: issue_valid=1. If stall=0: instruction consumed; pc<=pc+1 (31 wraps to 0); -> FETCH.
//      If stall=1: remain in ISSUE; every output bit held stable; pc unchanged.
//   HALTED: halted=1, issue_valid=0, no memory reads; start=1 -> clear halted, pc<=RESET_PC, FETCH.
//  start ignored in FETCH/WAIT/ISSUE.
//  Throughput: 3 cycles per non-stalled instruction. Latency: rd_en to issue_valid = 2 cycles.
//  Handshake: transfer occurs on the edge where issue_valid=1 && stall=0; exactly one transfer per fetched word.
//  Field outputs are meaningful only while issue_valid=1; they hold their last value otherwise.
//  No operand hazard checking; execute reads registers on its own.
//  JMP to its own address loops forever without issuing (legal, not detected).
// STRUCTURE
//  Shared package/include: opcode constants (OP_JMP, OP_HALT, ALU opcodes), field bit positions,
//  FSM state encodings.
//  Optional sub-module instr_field_split: purely combinational IR -> fields.
//  The rest is a single always block for the FSM/PC plus an output register block.
// TESTING
//  1. Reset low mid-WAIT with stall=0 -> all outputs 0, state IDLE immediately; no issue after release until start.
//  2. start; imem[0]=16'h1A4C -> issue_valid at cycle 3: opcode=1, am=1, rd=2, rs1=2, mem_addr=5'h0C, instr_mem_addr=0.
//  3. stall=1 for 4 cycles during ISSUE -> fields and instr_mem_addr constant, imem_rd_en=0; on release pc=1 fetched.
//  4. imem[2]=16'hE007 -> no issue_valid for addr 2; next imem_rd_en at imem_addr=7.
//  5. Run from pc=31 with a non-branch instruction -> next fetch address 0 (wrap).
//  6. imem[k]=16'hF000 -> halted=1, no further reads; start -> halted=0, fetch addr 0.

Source files
------------

// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode front end: widths, opcodes,
// instruction field positions and the fetch FSM encoding.
package fetch_decode_pkg;

    localparam int PC_W    = 5;
    localparam int INSTR_W = 16;

    localparam logic [PC_W-1:0] RESET_PC = 5'd0;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 12;
    localparam int AM_BIT   = 11;
    localparam int RD_HI    = 10;
    localparam int RD_LO    = 8;
    localparam int RS1_HI   = 7;
    localparam int RS1_LO   = 5;
    localparam int RS2_HI   = 4;
    localparam int RS2_LO   = 2;
    localparam int MADDR_HI = 4;
    localparam int MADDR_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE,
        ST_HALTED
    } fd_state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic       am;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [4:0] mem_addr;
    } instr_fields_t;

    // JMP and HALT are resolved in the front end and never reach execute
    function automatic logic is_local_op(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_HALT);
    endfunction

    function automatic logic [PC_W-1:0] pc_increment(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_decode_field_split.sv
// Purely combinational split of an instruction word into its decode fields.
module fetch_decode_field_split
    import fetch_decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output instr_fields_t      fields
);

    // mem_addr deliberately overlaps rs2; execute chooses between them using am
    assign fields.opcode   = instr[OPC_HI:OPC_LO];
    assign fields.am       = instr[AM_BIT];
    assign fields.rd       = instr[RD_HI:RD_LO];
    assign fields.rs1      = instr[RS1_HI:RS1_LO];
    assign fields.rs2      = instr[RS2_HI:RS2_LO];
    assign fields.mem_addr = instr[MADDR_HI:MADDR_LO];

endmodule

// File: rtl/fetch_decode.sv
// Front-end stage: fetches instruction words, decodes them into fields and
// presents one instruction at a time to execute with a valid/stall handshake.
module fetch_decode
    import fetch_decode_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    output logic               imem_rd_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               issue_valid,
    output logic [3:0]         opcode,
    output logic               am,
    output logic [2:0]         rd,
    output logic [2:0]         rs1,
    output logic [2:0]         rs2,
    output logic [4:0]         mem_addr,
    output logic [PC_W-1:0]    instr_mem_addr,
    output logic               halted
);

    fd_state_t       state;
    fd_state_t       state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] fetch_pc;
    logic [3:0]      ir_op;
    logic [4:0]      ir_target;
    instr_fields_t   data_fields;
    instr_fields_t   out_fields;

    fetch_decode_field_split u_field_split (
        .instr  (imem_data),
        .fields (data_fields)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    pc_nxt    = RESET_PC;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (ir_op == OP_JMP) begin
                    pc_nxt    = ir_target;
                    state_nxt = ST_FETCH;
                end else if (ir_op == OP_HALT) begin
                    state_nxt = ST_HALTED;
                end else if (!stall) begin
                    pc_nxt    = pc_increment(pc);
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (start) begin
                    pc_nxt    = RESET_PC;
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Only the opcode and jump target of the IR are needed once issued
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_op     <= '0;
            ir_target <= '0;
            fetch_pc  <= '0;
        end else if (state == ST_WAIT) begin
            ir_op     <= data_fields.opcode;
            ir_target <= data_fields.mem_addr;
            fetch_pc  <= pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_fields  <= '0;
            issue_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    out_fields  <= data_fields;
                    issue_valid <= !is_local_op(data_fields.opcode);
                end
                ST_ISSUE: begin
                    if (issue_valid && !stall) begin
                        issue_valid <= 1'b0;
                    end
                    if (ir_op == OP_HALT) begin
                        halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (start) begin
                        halted <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_rd_en     = (state == ST_FETCH);
    assign imem_addr      = imem_rd_en ? pc : '0;
    assign opcode         = out_fields.opcode;
    assign am             = out_fields.am;
    assign rd             = out_fields.rd;
    assign rs1            = out_fields.rs1;
    assign rs2            = out_fields.rs2;
    assign mem_addr       = out_fields.mem_addr;
    assign instr_mem_addr = fetch_pc;

endmodule

// File: tb/tb_fetch_decode.sv
// Randomised bench for fetch_decode: an instruction-level reference model
// predicts every fetch address, issued instruction and halt.
module tb_fetch_decode;
    import fetch_decode_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               stall;
    logic               imem_rd_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data = '0;
    logic               issue_valid;
    logic [3:0]         opcode;
    logic               am;
    logic [2:0]         rd;
    logic [2:0]         rs1;
    logic [2:0]         rs2;
    logic [4:0]         mem_addr;
    logic [PC_W-1:0]    instr_mem_addr;
    logic               halted;

    logic [15:0] mem [0:31];
    logic [31:0] all_outs;
    logic [31:0] issue_vec;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          fetch_cyc = -100;
    int          next_fetch = -1;
    int          transfers = 0;
    logic [4:0]  m_pc = '0;
    logic [4:0]  f_addr = '0;
    logic [15:0] f_word = '0;
    bit          m_run = 0;
    bit          m_halted = 0;
    bit          m_valid = 0;
    bit          hold_v = 0;
    bit          exp_h;
    logic [31:0] snap = '0;

    fetch_decode dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stall          (stall),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .issue_valid    (issue_valid),
        .opcode         (opcode),
        .am             (am),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .mem_addr       (mem_addr),
        .instr_mem_addr (instr_mem_addr),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= mem[imem_addr];
    end

    assign all_outs  = {imem_rd_en, imem_addr, issue_valid, opcode, am, rd, rs1, rs2,
                        mem_addr, instr_mem_addr, halted};
    assign issue_vec = {7'b0, issue_valid, opcode, am, rd, rs1, rs2, mem_addr, instr_mem_addr};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit start_v, input bit stall_v);
        @(posedge clk);
        #1;
        start = start_v;
        stall = stall_v;
    endtask

    task automatic waitFetch(input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            seen = imem_rd_en;
        end
        if (!seen) checkOutput("fetch_timeout", 0, 1);
    endtask

    function automatic logic [31:0] expectedIssue(input logic [15:0] w, input logic [4:0] a);
        return {7'b0, 1'b1, w[15:12], w[11], w[10:8], w[7:5], w[4:2], w[4:0], a};
    endfunction

    function automatic logic [15:0] randomWord();
        int r = $urandom_range(0, 11);
        if (r == 0) return {4'hF, 12'($urandom)};
        if (r == 1) return {4'hE, 7'($urandom), 5'($urandom_range(0, 31))};
        return {4'($urandom_range(0, 13)), 12'($urandom)};
    endfunction

    // Instruction-level model: walks the program as the architecture defines it
    always @(negedge clk) begin
        if (!reset) begin
            m_run = 0;
            m_halted = 0;
            m_valid = 0;
            hold_v = 0;
            fetch_cyc = -100;
            next_fetch = -1;
        end else begin
            cyc++;
            if (m_run) begin
                if (imem_rd_en) begin
                    checkOutput("fetch_cycle", cyc, next_fetch);
                    checkOutput("fetch_addr", 32'(imem_addr), 32'(m_pc));
                    fetch_cyc = cyc;
                    f_addr = imem_addr;
                    f_word = mem[imem_addr];
                    next_fetch = -1;
                    m_valid = 0;
                end else if (cyc == next_fetch) begin
                    checkOutput("fetch_missing", 0, 1);
                end
                if (hold_v) begin
                    checkOutput("stall_hold", issue_vec, snap);
                    hold_v = 0;
                end
                if (cyc == fetch_cyc + 2) begin
                    m_valid = (f_word[15:12] < 4'hE);
                    if (m_valid) checkOutput("issue_fields", issue_vec, expectedIssue(f_word, f_addr));
                    if (f_word[15:12] == 4'hE) begin
                        m_pc = f_word[4:0];
                        next_fetch = cyc + 1;
                    end
                end
                checkOutput("issue_valid", 32'(issue_valid), 32'(m_valid));
                exp_h = (f_word[15:12] == 4'hF) && (cyc == fetch_cyc + 3);
                checkOutput("halted", 32'(halted), 32'(exp_h));
                if (exp_h) begin
                    m_run = 0;
                    m_halted = 1;
                end else if (m_valid) begin
                    if (stall) begin
                        hold_v = 1;
                        snap = issue_vec;
                    end else begin
                        transfers++;
                        m_valid = 0;
                        m_pc = 5'((int'(f_addr) + 1) % 32);
                        next_fetch = cyc + 1;
                    end
                end
            end else begin
                checkOutput("idle_quiet", {29'b0, imem_rd_en, issue_valid, halted}, {31'b0, m_halted});
            end
            if (!m_run && start) begin
                m_run = 1;
                m_halted = 0;
                m_pc = 5'd0;
                next_fetch = cyc + 1;
                fetch_cyc = -100;
                m_valid = 0;
            end
        end
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = {4'($urandom_range(0, 13)), 12'($urandom)};
        mem[0] = 16'h1A4C;
        mem[2] = 16'hE007;
        mem[8] = 16'hF000;

        repeat (2) @(posedge clk);
        #1 checkOutput("reset_outputs", all_outs, 32'h0);
        @(posedge clk);
        #3 reset = 1'b1;

        // Async reset in the middle of WAIT must clear everything at once
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        waitFetch(8);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 checkOutput("async_reset", all_outs, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (5) applyStimulus(0, 0);

        // First instruction held by a 4-cycle stall, then run to the HALT at 8
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        waitFetch(8);
        #1 stall = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("first_issue", issue_vec,
                    {7'b0, 1'b1, 4'h1, 1'b1, 3'h2, 3'h2, 3'h3, 5'h0C, 5'h00});
        repeat (4) @(posedge clk);
        #1 stall = 1'b0;
        repeat (40) applyStimulus(0, 0);
        #1 checkOutput("halted_directed", 32'(halted), 32'h1);

        // Restart from HALTED; jump to 31 exercises the PC wrap back to 0
        mem[8]  = 16'hE01F;
        mem[31] = 16'h2345;
        applyStimulus(1, 0);
        repeat (70) applyStimulus(0, $urandom_range(0, 3) == 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) mem[i] = randomWord();
            @(posedge clk);
            #2 reset = 1'b0;
            @(posedge clk);
            #3 reset = 1'b1;
            for (int c = 0; c < 300; c++) begin
                applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
            end
        end

        checkOutput("transfers_seen", 32'(transfers > 3), 32'h1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
